// File: rtl/ext_reg_mailbox.sv
// Hardware endpoint of an hwext mailbox register: SW writes (qe) fill a TX FIFO drained by HW,
// HW fills an RX FIFO that SW reads (qre) with d presenting the RX head.
module ext_reg_mailbox #(
  parameter int unsigned  DW    = 32,
  parameter int unsigned  Depth = 4,
  localparam int unsigned CW    = $clog2(Depth + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          qe_i,
  input  logic [DW-1:0] q_i,
  input  logic          qre_i,
  output logic [DW-1:0] d_o,
  output logic          hw_tx_valid_o,
  output logic [DW-1:0] hw_tx_data_o,
  input  logic          hw_tx_ready_i,
  input  logic          hw_rx_valid_i,
  input  logic [DW-1:0] hw_rx_data_i,
  output logic          hw_rx_ready_o,
  output logic [CW-1:0] tx_depth_o,
  output logic [CW-1:0] rx_depth_o,
  output logic          wr_ovf_o,
  output logic          rd_udf_o,
  input  logic          err_clr_i
);

  localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [DW-1:0] tx_mem [Depth];
  logic [DW-1:0] rx_mem [Depth];

  logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic          wr_ovf_q, wr_ovf_d, rd_udf_q, rd_udf_d;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;

  // Full/empty come only from registered counts, so no input reaches an output combinationally.
  assign tx_full  = (tx_cnt_q == CW'(Depth));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(Depth));
  assign rx_empty = (rx_cnt_q == '0);

  assign tx_push = qe_i && !tx_full;
  assign tx_pop  = !tx_empty && hw_tx_ready_i;
  assign rx_push = hw_rx_valid_i && !rx_full;
  assign rx_pop  = qre_i && !rx_empty;

  assign hw_tx_valid_o = !tx_empty;
  assign hw_tx_data_o  = tx_empty ? '0 : tx_mem[tx_rp_q];
  assign hw_rx_ready_o = !rx_full;
  assign d_o           = rx_empty ? '0 : rx_mem[rx_rp_q];
  assign tx_depth_o    = tx_cnt_q;
  assign rx_depth_o    = rx_cnt_q;
  assign wr_ovf_o      = wr_ovf_q;
  assign rd_udf_o      = rd_udf_q;

  always_comb begin
    tx_wp_d  = tx_push ? tx_wp_q + PW'(1) : tx_wp_q;
    tx_rp_d  = tx_pop  ? tx_rp_q + PW'(1) : tx_rp_q;
    rx_wp_d  = rx_push ? rx_wp_q + PW'(1) : rx_wp_q;
    rx_rp_d  = rx_pop  ? rx_rp_q + PW'(1) : rx_rp_q;

    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + CW'(1);
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CW'(1);

    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + CW'(1);
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CW'(1);

    // A new error event outranks a clear in the same cycle.
    wr_ovf_d = (qe_i && tx_full)   || (wr_ovf_q && !err_clr_i);
    rd_udf_d = (qre_i && rx_empty) || (rd_udf_q && !err_clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      wr_ovf_q <= 1'b0;
      rd_udf_q <= 1'b0;
    end else begin
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      wr_ovf_q <= wr_ovf_d;
      rd_udf_q <= rd_udf_d;
    end
  end

  // Storage needs no reset: data outputs are masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wp_q] <= q_i;
    if (rx_push) rx_mem[rx_wp_q] <= hw_rx_data_i;
  end

endmodule

// File: tb/tb_ext_reg_mailbox.sv
// Scoreboard bench for ext_reg_mailbox: expected TX deliveries and SW read data are queued by
// the stimulus and checked by a negedge monitor; occupancy and flags are checked directly.
module tb_ext_reg_mailbox;

  logic        clk, rst_n;
  logic        qe, qre, tx_ready, rx_valid, err_clr;
  logic [31:0] q, rx_data, d, tx_data;
  logic        tx_valid, rx_ready, wr_ovf, rd_udf;
  logic [2:0]  tx_depth, rx_depth;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0] tx_q [$];
  logic [31:0] rd_q [$];

  ext_reg_mailbox #(.DW(32), .Depth(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .qe_i         (qe),
    .q_i          (q),
    .qre_i        (qre),
    .d_o          (d),
    .hw_tx_valid_o(tx_valid),
    .hw_tx_data_o (tx_data),
    .hw_tx_ready_i(tx_ready),
    .hw_rx_valid_i(rx_valid),
    .hw_rx_data_i (rx_data),
    .hw_rx_ready_o(rx_ready),
    .tx_depth_o   (tx_depth),
    .rx_depth_o   (rx_depth),
    .wr_ovf_o     (wr_ovf),
    .rd_udf_o     (rd_udf),
    .err_clr_i    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every TX handshake and every SW read strobe is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tx_unexpected: got %h expected no delivery", tx_data);
        end else begin
          chk("tx_deliver", tx_data, tx_q.pop_front());
        end
      end
      if (qre) begin
        if (rd_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rd_unexpected: got %h expected no read", d);
        end else begin
          chk("sw_read", d, rd_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; qe = 1'b0; q = '0; qre = 1'b0; tx_ready = 1'b0;
    rx_valid = 1'b0; rx_data = '0; err_clr = 1'b0;
    #12 rst_n = 1'b1;
    cyc();

    chk("rst_d",        d, 32'h0);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_tx_data",  tx_data, 32'h0);
    chk("rst_rx_ready", 32'(rx_ready), 32'h1);
    chk("rst_tx_depth", 32'(tx_depth), 32'h0);
    chk("rst_rx_depth", 32'(rx_depth), 32'h0);
    chk("rst_ovf",      32'(wr_ovf), 32'h0);
    chk("rst_udf",      32'(rd_udf), 32'h0);

    // TX basic: two writes, then drain
    qe = 1'b1; q = 32'hA5A5_0001; tx_q.push_back(q); cyc();
    chk("tx_latency_data", tx_data, 32'hA5A5_0001);
    chk("tx_depth_1",      32'(tx_depth), 32'h1);
    q = 32'hA5A5_0002; tx_q.push_back(q); cyc();
    qe = 1'b0;
    chk("tx_depth_2", 32'(tx_depth), 32'h2);
    chk("tx_head",    tx_data, 32'hA5A5_0001);
    chk("tx_valid",   32'(tx_valid), 32'h1);
    tx_ready = 1'b1; cyc(); cyc(); tx_ready = 1'b0;
    chk("tx_drained_depth", 32'(tx_depth), 32'h0);
    chk("tx_drained_valid", 32'(tx_valid), 32'h0);
    chk("tx_drained_data",  tx_data, 32'h0);

    // TX overflow: five writes into a four-deep FIFO
    qe = 1'b1;
    for (int i = 0; i < 5; i++) begin
      q = 32'h100 + 32'(i);
      if (i < 4) tx_q.push_back(q);
      cyc();
    end
    qe = 1'b0;
    chk("ovf_depth", 32'(tx_depth), 32'h4);
    chk("ovf_set",   32'(wr_ovf), 32'h1);
    chk("ovf_head",  tx_data, 32'h100);
    qe = 1'b1; q = 32'h1FF; err_clr = 1'b1; cyc();
    qe = 1'b0;
    chk("ovf_set_beats_clr", 32'(wr_ovf), 32'h1);
    cyc();
    err_clr = 1'b0;
    chk("ovf_cleared",     32'(wr_ovf), 32'h0);
    chk("ovf_depth_keep",  32'(tx_depth), 32'h4);
    qe = 1'b1; q = 32'h2AA; tx_ready = 1'b1; cyc();
    qe = 1'b0;
    chk("full_push_pop_depth", 32'(tx_depth), 32'h3);
    chk("full_push_pop_ovf",   32'(wr_ovf), 32'h1);
    cyc(); cyc(); cyc(); tx_ready = 1'b0;
    chk("ovf_drained", 32'(tx_depth), 32'h0);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    chk("ovf_cleared2", 32'(wr_ovf), 32'h0);

    // TX simultaneous push and pop keeps count
    qe = 1'b1; q = 32'h300; tx_q.push_back(q); cyc();
    q = 32'h301; tx_q.push_back(q); tx_ready = 1'b1; cyc();
    qe = 1'b0;
    chk("tx_pushpop_depth", 32'(tx_depth), 32'h1);
    cyc(); tx_ready = 1'b0;
    chk("tx_pushpop_empty", 32'(tx_depth), 32'h0);

    // RX basic reads and underflow
    rx_valid = 1'b1; rx_data = 32'h11; cyc();
    rx_data = 32'h22; cyc();
    rx_valid = 1'b0;
    chk("rx_depth_2", 32'(rx_depth), 32'h2);
    chk("rx_head",    d, 32'h11);
    qre = 1'b1; rd_q.push_back(32'h11); cyc(); qre = 1'b0;
    chk("rx_after_pop_d",     d, 32'h22);
    chk("rx_after_pop_depth", 32'(rx_depth), 32'h1);
    qre = 1'b1; rd_q.push_back(32'h22); cyc(); qre = 1'b0;
    chk("rx_empty_depth", 32'(rx_depth), 32'h0);
    chk("rx_empty_d",     d, 32'h0);
    qre = 1'b1; rd_q.push_back(32'h0); cyc(); qre = 1'b0;
    chk("udf_set",   32'(rd_udf), 32'h1);
    chk("udf_depth", 32'(rx_depth), 32'h0);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    chk("udf_cleared", 32'(rd_udf), 32'h0);

    // RX full backpressure and ordering across pointer wrap
    rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_data = 32'(i); cyc();
    end
    rx_data = 32'h4; cyc();
    chk("rx_full_ready", 32'(rx_ready), 32'h0);
    chk("rx_full_depth", 32'(rx_depth), 32'h4);
    qre = 1'b1; rd_q.push_back(32'h0); cyc(); qre = 1'b0;
    chk("rx_reopen_ready", 32'(rx_ready), 32'h1);
    chk("rx_reopen_depth", 32'(rx_depth), 32'h3);
    cyc();
    rx_valid = 1'b0;
    chk("rx_refill_depth", 32'(rx_depth), 32'h4);
    chk("rx_refill_ready", 32'(rx_ready), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      qre = 1'b1; rd_q.push_back(32'(i)); cyc();
    end
    qre = 1'b0;
    chk("rx_wrap_empty", 32'(rx_depth), 32'h0);
    rx_valid = 1'b1; rx_data = 32'h5; cyc();
    rx_data = 32'h6; qre = 1'b1; rd_q.push_back(32'h5); cyc();
    chk("rx_pushpop_depth", 32'(rx_depth), 32'h1);
    rx_data = 32'h7; rd_q.push_back(32'h6); cyc();
    rx_valid = 1'b0; rd_q.push_back(32'h7); cyc();
    qre = 1'b0;
    chk("rx_final_depth", 32'(rx_depth), 32'h0);
    chk("rx_final_d",     d, 32'h0);

    // Asynchronous reset mid-stream
    qe = 1'b1; q = 32'h500; qre = 1'b1; rd_q.push_back(32'h0); cyc();
    qre = 1'b0; q = 32'h501; rx_valid = 1'b1; rx_data = 32'h600; cyc();
    q = 32'h502; rx_data = 32'h601; cyc();
    qe = 1'b0; rx_valid = 1'b0;
    chk("pre_rst_tx_depth", 32'(tx_depth), 32'h3);
    chk("pre_rst_rx_depth", 32'(rx_depth), 32'h2);
    chk("pre_rst_udf",      32'(rd_udf), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_tx_depth", 32'(tx_depth), 32'h0);
    chk("arst_rx_depth", 32'(rx_depth), 32'h0);
    chk("arst_tx_valid", 32'(tx_valid), 32'h0);
    chk("arst_tx_data",  tx_data, 32'h0);
    chk("arst_rx_ready", 32'(rx_ready), 32'h1);
    chk("arst_d",        d, 32'h0);
    chk("arst_udf",      32'(rd_udf), 32'h0);
    chk("arst_ovf",      32'(wr_ovf), 32'h0);
    #1 rst_n = 1'b1;
    tx_ready = 1'b1;
    cyc(); cyc(); cyc();
    tx_ready = 1'b0;
    chk("post_rst_tx_depth", 32'(tx_depth), 32'h0);
    chk("post_rst_tx_valid", 32'(tx_valid), 32'h0);

    cyc();
    chk("tx_scoreboard_empty", 32'(tx_q.size()), 32'h0);
    chk("rd_scoreboard_empty", 32'(rd_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
